// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one partial product per clock,
// unsigned or two's-complement signed operands, start/busy/done handshake.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state,  state_nxt;
    logic [PW-1:0]    mcand,  mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [PW-1:0]    acc,    acc_nxt;
    logic [CNT_W-1:0] cnt,    cnt_nxt;
    logic             neg,    neg_nxt;
    logic             busy_nxt, done_nxt;
    logic [PW-1:0]    p_nxt;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    acc_sum;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // exactly 2^(WIDTH-1) when read as unsigned.
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (sgn && A[WIDTH-1]) a_mag = WIDTH'(~A + WIDTH'(1));
        if (sgn && B[WIDTH-1]) b_mag = WIDTH'(~B + WIDTH'(1));
    end

    // Accumulator plus the current partial product.
    always_comb begin
        acc_sum = mplier[0] ? PW'(acc + mcand) : acc;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        neg_nxt    = neg;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        p_nxt      = P;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    busy_nxt   = 1'b1;
                    mcand_nxt  = PW'(a_mag);
                    mplier_nxt = b_mag;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    neg_nxt    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                end
            end
            ST_RUN: begin
                busy_nxt   = 1'b1;
                acc_nxt    = acc_sum;
                mcand_nxt  = PW'(mcand << 1);
                mplier_nxt = WIDTH'(mplier >> 1);
                cnt_nxt    = CNT_W'(cnt + CNT_W'(1));
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    p_nxt     = neg ? PW'(~acc_sum + PW'(1)) : acc_sum;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            P      <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            neg    <= neg_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            P      <= p_nxt;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=4) against an arithmetic model.
module tb_seq_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sgn;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [PW-1:0] p;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .P     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic, truncated to 2*W bits.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        int sx, sy;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        return PW'(sx * sy);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE
    // cycle so a subsequent call starts back-to-back. With hold=1, start stays
    // high and the operand inputs churn every cycle after the accepted edge.
    task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input bit hold, input logic [PW-1:0] exp);
        logic [PW-1:0] prev;
        prev  = p;
        start = 1'b1;
        a     = x;
        b     = y;
        sgn   = s;
        @(negedge clk);
        for (int k = 0; k < int'(W); k++) begin
            check("busy_in_run", 32'(busy), 32'd1);
            check("done_in_run", 32'(done), 32'd0);
            check("p_held_in_run", 32'(p), 32'(prev));
            start = hold;
            a     = W'($urandom);
            b     = W'($urandom);
            sgn   = 1'($urandom);
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("product", 32'(p), 32'(exp));
        @(negedge clk);
        check("done_cleared", 32'(done), 32'd0);
        check("busy_in_idle", 32'(busy), 32'd0);
        check("p_held_in_idle", 32'(p), 32'(exp));
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic         rs;

        rst_n = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed products.
        do_mul(4'd15, 4'd15, 1'b0, 1'b0, 8'hE1);
        do_mul(4'b1000, 4'b1000, 1'b1, 1'b0, 8'h40);
        do_mul(4'b1101, 4'd5, 1'b1, 1'b0, 8'hF1);
        do_mul(4'd0, 4'b1000, 1'b1, 1'b0, 8'h00);
        do_mul(4'd3, 4'd3, 1'b0, 1'b0, 8'h09);
        do_mul(4'd7, 4'b1000, 1'b1, 1'b0, 8'hC8);
        do_mul(4'hF, 4'hF, 1'b1, 1'b0, 8'h01);
        do_mul(4'b1000, 4'd1, 1'b1, 1'b0, 8'hF8);

        // Exhaustive sweep in both modes, back-to-back starts.
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    do_mul(W'(x), W'(y), 1'(s), 1'b0,
                           ref_mul(W'(x), W'(y), 1'(s)));

        // start held high, operands churning; only accepted edges matter.
        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rs = 1'($urandom);
            do_mul(rx, ry, rs, 1'b1, ref_mul(rx, ry, rs));
        end
        start = 1'b0;

        // Make sure P is non-zero, then reset in the middle of RUN.
        do_mul(4'd5, 4'd3, 1'b0, 1'b0, 8'h0F);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd7;
        sgn   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        check("midrun_reset_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done), 32'd0);
            check("idle_after_reset", 32'(busy), 32'd0);
        end

        // Recovery after reset.
        for (int i = 0; i < 10; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rs = 1'($urandom);
            do_mul(rx, ry, rs, 1'b0, ref_mul(rx, ry, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, sequential shift-and-add multiplier. Successor to the combinational 2-bit multiplier.
- Multiplies two WIDTH-bit operands, either unsigned or two's-complement signed, one bit per clock.
- Uses a start/busy/done handshake so datapath labs can drive it from a controller FSM or a testbench.
- The product is held stable until the next accepted start.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16). Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- sgn  input  1  1 = treat A/B as two's-complement signed; sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: P holds a new valid result
- P  output  2*WIDTH  product register

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, P=0, internal registers cleared.
  - Any in-flight operation is abandoned, with no done pulse.
  - Operation resumes on the first rising edge after rst_n=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a rising edge (edge t0), latch the operands and go to RUN. Iteration counter = 0.
  - Operand latching in signed mode (sgn=1): latch |A| and |B| as WIDTH-bit magnitudes. Record neg = A[MSB] XOR B[MSB].
  - Operand latching in unsigned mode (sgn=0): latch A and B as-is, neg=0.
  - If start=0, stay in IDLE.
- RUN:
  - busy=1.
  - Each edge t0+1 .. t0+WIDTH performs one iteration: if the multiplier LSB = 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter.
  - At edge t0+WIDTH (counter reaches WIDTH-1 → final iteration), go to DONE.
  - On that same edge, load P with the accumulator result, negated (two's complement, modulo 2^(2*WIDTH)) if neg=1.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Go to IDLE at edge t0+WIDTH+1.
- Latency: done is asserted in the WIDTH-th cycle after the start edge. Minimum start-to-start period is WIDTH+2 cycles.
- start is ignored in RUN and DONE: no queuing, no restart. The A/B/sgn inputs may change freely after the start edge.
- P is updated only on the edge entering DONE (or by reset). It holds its value through IDLE and the whole of the next RUN.
- Arithmetic rules:
  - All intermediate sums are 2*WIDTH bits wide and cannot overflow.
  - Signed mode: the most-negative operand -2^(WIDTH-1) is handled correctly. Its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - Signed mode: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in the signed 2*WIDTH-bit result.
  - Zero operands: P=0, with no negative zero (negating 0 gives 0).
- busy and done are never high in the same cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=2, sgn=0, all 16 A/B pairs, each started from IDLE → done after 2 cycles; P = A*B, e.g. A=3, B=3 → P=4'b1001.
- WIDTH=4, sgn=0, A=15, B=15 → done exactly 4 cycles after the start edge, P=8'hE1; busy high for 4 cycles; done high for 1 cycle.
- WIDTH=4, sgn=1:
  - A=4'b1000 (-8), B=4'b1000 → P=8'h40 (64)
  - A=4'b1101 (-3), B=5 → P=8'hF1 (-15)
  - A=0, B=4'b1000 → P=0
- start held high continuously with A/B changed every cycle during RUN → only the operands at the accepted edges are used. P is stable between done pulses. Accepted starts occur every WIDTH+2 cycles.
- rst_n pulled low for 1 cycle in the middle of RUN → busy, done and P go to 0 immediately (asynchronous). No done pulse follows. The next start yields a correct product.
- Back-to-back: start asserted on the first IDLE cycle after DONE → new operation accepted. The previous P is held until the new done pulse.
